// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit direction counters.
// Combinational IF-stage lookup with same-cycle update bypass; one-cycle EX training port.
module btb_assoc #(
  parameter int unsigned SETS_LOG2 = 4,
  parameter int unsigned WAYS      = 2,
  parameter int unsigned IDX_LSB   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  output logic        hit,
  output logic        predict_taken,
  output logic [31:0] predicted_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        flush
);

  localparam int unsigned SETS  = 1 << SETS_LOG2;
  localparam int unsigned TAG_W = 32 - IDX_LSB - SETS_LOG2;
  // rr pointer is kept 1 bit wide when direct-mapped; it never advances in that case.
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic             valid_q  [SETS][WAYS];
  logic [TAG_W-1:0] tag_q    [SETS][WAYS];
  logic [31:0]      target_q [SETS][WAYS];
  logic [1:0]       ctr_q    [SETS][WAYS];
  logic [WAY_W-1:0] rr_q     [SETS];

  logic [SETS_LOG2-1:0] if_idx;
  logic [SETS_LOG2-1:0] upd_idx;
  logic [TAG_W-1:0]     if_tag;
  logic [TAG_W-1:0]     upd_tag;

  assign if_idx  = pc_if[IDX_LSB +: SETS_LOG2];
  assign upd_idx = upd_pc[IDX_LSB +: SETS_LOG2];
  assign if_tag  = pc_if[31 -: TAG_W];
  assign upd_tag = upd_pc[31 -: TAG_W];

  logic unused_low_bits;
  assign unused_low_bits = ^{pc_if[IDX_LSB-1:0], upd_pc[IDX_LSB-1:0]};

  // Lookup against stored state.
  logic        lk_hit;
  logic [1:0]  lk_ctr;
  logic [31:0] lk_target;

  always_comb begin
    lk_hit    = 1'b0;
    lk_ctr    = 2'b00;
    lk_target = 32'h0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[if_idx][w] && (tag_q[if_idx][w] == if_tag)) begin
        lk_hit    = 1'b1;
        lk_ctr    = ctr_q[if_idx][w];
        lk_target = target_q[if_idx][w];
      end
    end
  end

  // Update path: way selection and post-update entry contents.
  logic             upd_match;
  logic [WAY_W-1:0] match_way;
  logic             has_invalid;
  logic [WAY_W-1:0] inv_way;
  logic [1:0]       old_ctr;
  logic [31:0]      old_target;
  logic             wr_en;
  logic [WAY_W-1:0] wr_way;
  logic [1:0]       new_ctr;
  logic [31:0]      new_target;
  logic             rr_adv;

  always_comb begin
    upd_match   = 1'b0;
    match_way   = '0;
    has_invalid = 1'b0;
    inv_way     = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
        upd_match = 1'b1;
        match_way = WAY_W'(w);
      end
      if (!valid_q[upd_idx][w] && !has_invalid) begin
        has_invalid = 1'b1;
        inv_way     = WAY_W'(w);
      end
    end
  end

  always_comb begin
    old_ctr    = ctr_q[upd_idx][match_way];
    old_target = target_q[upd_idx][match_way];
    wr_en      = 1'b0;
    wr_way     = match_way;
    new_ctr    = old_ctr;
    new_target = old_target;
    rr_adv     = 1'b0;
    if (upd_valid) begin
      if (upd_match) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          new_ctr    = (old_ctr == 2'b11) ? 2'b11 : old_ctr + 2'b01;
          new_target = upd_target;
        end else begin
          new_ctr = (old_ctr == 2'b00) ? 2'b00 : old_ctr - 2'b01;
        end
      end else if (upd_taken) begin
        wr_en      = 1'b1;
        new_ctr    = 2'b10;
        new_target = upd_target;
        if (has_invalid) begin
          wr_way = inv_way;
        end else begin
          wr_way = rr_q[upd_idx];
          rr_adv = (WAYS > 1);
        end
      end
    end
  end

  // Bypass only when the update actually writes the entry being looked up.
  logic        bypass;
  logic        out_hit;
  logic [1:0]  out_ctr;
  logic [31:0] out_target;

  assign bypass = wr_en && !flush && (upd_pc[31:IDX_LSB] == pc_if[31:IDX_LSB]);

  always_comb begin
    out_hit    = lk_hit;
    out_ctr    = lk_ctr;
    out_target = lk_target;
    if (bypass) begin
      out_hit    = 1'b1;
      out_ctr    = new_ctr;
      out_target = new_target;
    end
  end

  assign hit           = out_hit;
  assign predict_taken = out_hit && out_ctr[1];
  assign predicted_pc  = predict_taken ? out_target : pc_if + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) begin
          valid_q[s][w]  <= 1'b0;
          tag_q[s][w]    <= '0;
          target_q[s][w] <= 32'h0;
          ctr_q[s][w]    <= 2'b00;
        end
      end
    end else if (flush) begin
      // Contents stay stale; only validity and replacement state are cleared.
      for (int s = 0; s < int'(SETS); s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) begin
          valid_q[s][w] <= 1'b0;
        end
      end
    end else if (wr_en) begin
      valid_q[upd_idx][wr_way]  <= 1'b1;
      tag_q[upd_idx][wr_way]    <= upd_tag;
      target_q[upd_idx][wr_way] <= new_target;
      ctr_q[upd_idx][wr_way]    <= new_ctr;
      if (rr_adv) begin
        rr_q[upd_idx] <= rr_q[upd_idx] + WAY_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed scenarios plus randomized traffic
// checked against a table-level reference model.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        hit;
  logic        predict_taken;
  logic [31:0] predicted_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  btb_assoc #(
    .SETS_LOG2(4),
    .WAYS(2),
    .IDX_LSB(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc_if(pc_if),
    .hit(hit),
    .predict_taken(predict_taken),
    .predicted_pc(predicted_pc),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .flush(flush)
  );

  // Reference model: 16 sets x 2 ways, entries found by searching the set.
  bit          m_valid [16][2];
  logic [25:0] m_tag   [16][2];
  logic [31:0] m_tgt   [16][2];
  int          m_ctr   [16][2];
  int          m_rr    [16];

  function automatic void m_reset();
    for (int s = 0; s < 16; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0;
        m_tag[s][w]   = '0;
        m_tgt[s][w]   = '0;
        m_ctr[s][w]   = 0;
      end
    end
  endfunction

  function automatic void m_flush();
    for (int s = 0; s < 16; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 2; w++) m_valid[s][w] = 0;
    end
  endfunction

  function automatic void m_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
    int s;
    int way;
    s   = int'(pc[5:2]);
    way = -1;
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == pc[31:6]) way = w;
    if (way >= 0) begin
      if (taken) begin
        m_ctr[s][way] = (m_ctr[s][way] < 3) ? m_ctr[s][way] + 1 : 3;
        m_tgt[s][way] = tgt;
      end else begin
        m_ctr[s][way] = (m_ctr[s][way] > 0) ? m_ctr[s][way] - 1 : 0;
      end
    end else if (taken) begin
      if (!m_valid[s][0]) way = 0;
      else if (!m_valid[s][1]) way = 1;
      else begin
        way     = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % 2;
      end
      m_valid[s][way] = 1;
      m_tag[s][way]   = pc[31:6];
      m_tgt[s][way]   = tgt;
      m_ctr[s][way]   = 2;
    end
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit h, output bit pt,
                                   output logic [31:0] ppc);
    int s;
    s   = int'(pc[5:2]);
    h   = 0;
    pt  = 0;
    ppc = pc + 32'd4;
    for (int w = 0; w < 2; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == pc[31:6]) begin
        h  = 1;
        pt = (m_ctr[s][w] >= 2);
        if (pt) ppc = m_tgt[s][w];
      end
    end
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    upd_valid = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    @(posedge clk);
    #1 upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    // An update sampled while rst is high must be discarded.
    rst        = 1'b1;
    upd_valid  = 1'b1;
    upd_pc     = 32'h100;
    upd_taken  = 1'b1;
    upd_target = 32'h200;
    @(posedge clk);
    #1 rst = 1'b0;
    upd_valid = 1'b0;
    pc_if = 32'h100;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL reset_hit: got %b want 0", hit);
    end
    checks++;
    if (predict_taken !== 1'b0) begin
      errors++; $display("FAIL reset_taken: got %b want 0", predict_taken);
    end
    checks++;
    if (predicted_pc !== 32'h104) begin
      errors++; $display("FAIL reset_npc: got %h want 00000104", predicted_pc);
    end
    pc_if = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (predicted_pc !== 32'h0) begin
      errors++; $display("FAIL reset_wrap: got %h want 00000000", predicted_pc);
    end
  endtask

  task automatic test_alloc();
    upd(32'h100, 1'b1, 32'h200);
    pc_if = 32'h100;
    #1;
    checks++;
    if ({hit, predict_taken} !== 2'b11) begin
      errors++; $display("FAIL alloc_hit_taken: got %b%b want 11", hit, predict_taken);
    end
    checks++;
    if (predicted_pc !== 32'h200) begin
      errors++; $display("FAIL alloc_npc: got %h want 00000200", predicted_pc);
    end
  endtask

  task automatic test_training();
    pc_if = 32'h100;
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    #1;
    checks++;
    if ({hit, predict_taken} !== 2'b10 || predicted_pc !== 32'h104) begin
      errors++;
      $display("FAIL train_nt2: got hit=%b taken=%b npc=%h want 1 0 00000104",
               hit, predict_taken, predicted_pc);
    end
    upd(32'h100, 1'b1, 32'h200);
    #1;
    checks++;
    if (predict_taken !== 1'b0) begin
      errors++; $display("FAIL train_ctr01: got %b want 0", predict_taken);
    end
    upd(32'h100, 1'b1, 32'h200);
    #1;
    checks++;
    if (predicted_pc !== 32'h200) begin
      errors++; $display("FAIL train_ctr10: got %h want 00000200", predicted_pc);
    end
    repeat (3) upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    #1;
    checks++;
    if (predict_taken !== 1'b1 || predicted_pc !== 32'h200) begin
      errors++;
      $display("FAIL train_sat: got taken=%b npc=%h want 1 00000200", predict_taken, predicted_pc);
    end
  endtask

  task automatic test_replacement();
    logic [31:0] pcs [3];
    logic [2:0]  want;
    logic [2:0]  got;
    do_reset();
    upd(32'h100, 1'b1, 32'h1000);
    upd(32'h140, 1'b1, 32'h1400);
    upd(32'h180, 1'b1, 32'h1800);
    pcs  = '{32'h100, 32'h140, 32'h180};
    want = 3'b011;
    for (int i = 0; i < 3; i++) begin
      pc_if = pcs[i];
      #1 got[2-i] = hit;
    end
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL repl_first: hits(100,140,180) got %b want %b", got, want);
    end
    upd(32'h1C0, 1'b1, 32'h1C00);
    pcs  = '{32'h140, 32'h180, 32'h1C0};
    for (int i = 0; i < 3; i++) begin
      pc_if = pcs[i];
      #1 got[2-i] = hit;
    end
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL repl_rr: hits(140,180,1C0) got %b want %b", got, want);
    end
  endtask

  task automatic test_bypass();
    upd_valid  = 1'b1;
    upd_pc     = 32'h300;
    upd_taken  = 1'b1;
    upd_target = 32'h400;
    pc_if      = 32'h300;
    #1;
    checks++;
    if (hit !== 1'b1 || predicted_pc !== 32'h400) begin
      errors++; $display("FAIL bypass: got hit=%b npc=%h want 1 00000400", hit, predicted_pc);
    end
    @(posedge clk);
    #1 upd_valid = 1'b0;
  endtask

  task automatic test_flush();
    upd(32'h100, 1'b1, 32'h200);
    flush      = 1'b1;
    upd_valid  = 1'b1;
    upd_pc     = 32'h500;
    upd_taken  = 1'b1;
    upd_target = 32'h900;
    pc_if      = 32'h100;
    #1;
    checks++;
    if (hit !== 1'b1) begin
      errors++; $display("FAIL flush_preview: got hit=%b want 1", hit);
    end
    pc_if = 32'h500;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL flush_nobypass: got hit=%b want 0", hit);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    upd_valid = 1'b0;
    pc_if = 32'h100;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL flush_clear100: got hit=%b want 0", hit);
    end
    pc_if = 32'h500;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL flush_drop500: got hit=%b want 0", hit);
    end
    upd(32'h600, 1'b0, 32'h700);
    pc_if = 32'h600;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL nt_no_alloc: got hit=%b want 0", hit);
    end
  endtask

  task automatic test_random();
    bit          eh;
    bit          ept;
    logic [31:0] eppc;
    bit          same;
    do_reset();
    m_reset();
    for (int i = 0; i < 600; i++) begin
      upd_valid  = ($urandom_range(0, 3) != 0);
      upd_pc     = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      upd_taken  = $urandom_range(0, 2) != 0;
      upd_target = $urandom;
      flush      = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 7))
        0:       pc_if = 32'hFFFF_FFFC;
        1, 2, 3: pc_if = {upd_pc[31:2], 2'(($urandom_range(0, 3)))};
        default: pc_if = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2)
                         | $urandom_range(0, 3);
      endcase
      same = (pc_if[31:2] == upd_pc[31:2]);
      if (upd_valid && !flush && same) begin
        m_update(upd_pc, upd_taken, upd_target);
        m_lookup(pc_if, eh, ept, eppc);
      end else begin
        m_lookup(pc_if, eh, ept, eppc);
        if (flush) m_flush();
        else if (upd_valid) m_update(upd_pc, upd_taken, upd_target);
      end
      #1;
      checks++;
      if (hit !== eh) begin
        errors++; $display("FAIL rand_hit[%0d]: pc=%h got %b want %b", i, pc_if, hit, eh);
      end
      checks++;
      if (predict_taken !== ept) begin
        errors++;
        $display("FAIL rand_taken[%0d]: pc=%h got %b want %b", i, pc_if, predict_taken, ept);
      end
      checks++;
      if (predicted_pc !== eppc) begin
        errors++;
        $display("FAIL rand_npc[%0d]: pc=%h got %h want %h", i, pc_if, predicted_pc, eppc);
      end
      @(posedge clk);
      #1;
    end
    upd_valid = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    pc_if      = 32'h0;
    upd_valid  = 1'b0;
    upd_pc     = 32'h0;
    upd_taken  = 1'b0;
    upd_target = 32'h0;
    flush      = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_alloc();
    test_training();
    test_replacement();
    test_bypass();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
